stream_arbiter: RTL and testbench

- N-input to 1-output AXI-Stream packet arbiter for sharing one downstream stream resource (e.g. a single filter or DAC channel) between several producers.
- Arbitration uses priority-encoder selection over the requesting inputs, either fixed-priority or round-robin.
- A grant is locked for a whole packet and released only after the beat carrying tlast is accepted.

---
 rtl/stream_arbiter.sv | 61 ++++++
 tb/tb_stream_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/stream_arbiter.sv
// stream_arbiter: N-to-1 AXI-Stream packet arbiter with fixed or round-robin priority and per-packet grant lock
module stream_arbiter #(
  parameter int N = 4,
  parameter int DW = 24,
  parameter int ROUND_ROBIN = 1,
  parameter int LSB_PRIORITY = 1,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*DW-1:0] s_axis_tdata,
  input  logic [N-1:0]    s_axis_tvalid,
  input  logic [N-1:0]    s_axis_tlast,
  output logic [N-1:0]    s_axis_tready,
  output logic [DW-1:0]   m_axis_tdata,
  output logic            m_axis_tvalid,
  output logic            m_axis_tlast,
  input  logic            m_axis_tready,
  output logic [IW-1:0]   m_axis_tid,
  output logic            busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  logic [0:0] state;
  logic [IW-1:0] g, last, lo, hi, win;
  logic [N-1:0] mreq, sel;
  logic active;
  // round-robin: prefer requesters above the last grant, otherwise wrap to the full set
  always_comb begin
    mreq = '0;
    for (int i = 0; i < N; i++) mreq[i] = s_axis_tvalid[i] && (i > int'(last));
    sel = (ROUND_ROBIN != 0 && |mreq) ? mreq : s_axis_tvalid;
    lo = '0;
    hi = '0;
    for (int i = N - 1; i >= 0; i--) if (sel[i]) lo = IW'(i);
    for (int i = 0; i < N; i++) if (s_axis_tvalid[i]) hi = IW'(i);
    win = (ROUND_ROBIN != 0 || LSB_PRIORITY != 0) ? lo : hi;
  end
  assign active = state == GRANT;
  assign m_axis_tdata = active ? s_axis_tdata[g*DW +: DW] : '0;
  assign m_axis_tvalid = active & s_axis_tvalid[g];
  assign m_axis_tlast = active & s_axis_tlast[g];
  assign s_axis_tready = active ? (N'(m_axis_tready) << g) : '0;
  assign m_axis_tid = g;
  assign busy = active;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      g <= '0;
      last <= IW'(N - 1);
    end else if (state == IDLE) begin
      if (|s_axis_tvalid) begin
        state <= GRANT;
        g <= win;
        last <= win;
      end
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_stream_arbiter.sv
// tb_stream_arbiter: table-driven check of round-robin and fixed-priority arbitration
module tb_stream_arbiter;
  typedef struct {
    logic rst;
    logic [3:0] vld, lst;
    logic rdy;
    logic busy;
    logic [1:0] tid;
    logic mv, ml;
    logic [3:0] sr;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, mr;
  logic [95:0] sd;
  logic [3:0] sv, sl, sr_rr, sr_fp;
  logic [23:0] md_rr, md_fp;
  logic mv_rr, ml_rr, busy_rr, mv_fp, ml_fp, busy_fp;
  logic [1:0] tid_rr, tid_fp;
  logic [23:0] dat [4];
  int n_chk = 0;
  int n_fail = 0;
  vec_t tv[$];
  vec_t fv[$];
  stream_arbiter dut_rr (
    .clk(clk), .rst(rst), .s_axis_tdata(sd), .s_axis_tvalid(sv), .s_axis_tlast(sl),
    .s_axis_tready(sr_rr), .m_axis_tdata(md_rr), .m_axis_tvalid(mv_rr), .m_axis_tlast(ml_rr),
    .m_axis_tready(mr), .m_axis_tid(tid_rr), .busy(busy_rr)
  );
  stream_arbiter #(.ROUND_ROBIN(0), .LSB_PRIORITY(1)) dut_fp (
    .clk(clk), .rst(rst), .s_axis_tdata(sd), .s_axis_tvalid(sv), .s_axis_tlast(sl),
    .s_axis_tready(sr_fp), .m_axis_tdata(md_fp), .m_axis_tvalid(mv_fp), .m_axis_tlast(ml_fp),
    .m_axis_tready(mr), .m_axis_tid(tid_fp), .busy(busy_fp)
  );
  function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l, logic y, logic b,
                              logic [1:0] id, logic m, logic t, logic [3:0] s);
    vec_t x;
    x.rst = r; x.vld = v; x.lst = l; x.rdy = y;
    x.busy = b; x.tid = id; x.mv = m; x.ml = t; x.sr = s;
    return x;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(input vec_t t, input bit fp, input string tag);
    rst = t.rst; sv = t.vld; sl = t.lst; mr = t.rdy;
    @(negedge clk);
    chk({tag, " busy"}, fp ? busy_fp : busy_rr, t.busy);
    chk({tag, " tid"}, fp ? tid_fp : tid_rr, t.tid);
    chk({tag, " mvalid"}, fp ? mv_fp : mv_rr, t.mv);
    chk({tag, " mlast"}, fp ? ml_fp : ml_rr, t.ml);
    chk({tag, " sready"}, fp ? sr_fp : sr_rr, t.sr);
    chk({tag, " tdata"}, fp ? md_fp : md_rr, t.busy ? dat[t.tid] : 24'h0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 4; i++) dat[i] = 24'h111111 * (i + 1);
    sd = {dat[3], dat[2], dat[1], dat[0]};
    // round-robin after reset: 0,1,2,3,0 with a bubble between grants
    tv.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 0, 0, 0, 4'b0000));
    tv.push_back(mk(0, 4'b1111, 4'b1111, 1, 1, 0, 1, 1, 4'b0001));
    tv.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 0, 0, 0, 4'b0000));
    tv.push_back(mk(0, 4'b1111, 4'b1111, 1, 1, 1, 1, 1, 4'b0010));
    tv.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 1, 0, 0, 4'b0000));
    tv.push_back(mk(0, 4'b1111, 4'b1111, 1, 1, 2, 1, 1, 4'b0100));
    tv.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 2, 0, 0, 4'b0000));
    tv.push_back(mk(0, 4'b1111, 4'b1111, 1, 1, 3, 1, 1, 4'b1000));
    tv.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 3, 0, 0, 4'b0000));
    tv.push_back(mk(0, 4'b1111, 4'b1111, 1, 1, 0, 1, 1, 4'b0001));
    // wrap: grant 3, then 1001 -> 0, then 1100 -> 2
    tv.push_back(mk(0, 4'b1000, 4'b1000, 1, 0, 0, 0, 0, 4'b0000));
    tv.push_back(mk(0, 4'b1000, 4'b1000, 1, 1, 3, 1, 1, 4'b1000));
    tv.push_back(mk(0, 4'b1001, 4'b1001, 1, 0, 3, 0, 0, 4'b0000));
    tv.push_back(mk(0, 4'b1001, 4'b1001, 1, 1, 0, 1, 1, 4'b0001));
    tv.push_back(mk(0, 4'b1100, 4'b1100, 1, 0, 0, 0, 0, 4'b0000));
    tv.push_back(mk(0, 4'b1100, 4'b1100, 1, 1, 2, 1, 1, 4'b0100));
    // packet lock with gaps while input 1 keeps requesting
    tv.push_back(mk(0, 4'b0011, 4'b0000, 1, 0, 2, 0, 0, 4'b0000));
    tv.push_back(mk(0, 4'b0011, 4'b0000, 1, 1, 0, 1, 0, 4'b0001));
    tv.push_back(mk(0, 4'b0010, 4'b0000, 1, 1, 0, 0, 0, 4'b0001));
    tv.push_back(mk(0, 4'b0011, 4'b0000, 1, 1, 0, 1, 0, 4'b0001));
    tv.push_back(mk(0, 4'b0010, 4'b0000, 1, 1, 0, 0, 0, 4'b0001));
    tv.push_back(mk(0, 4'b0011, 4'b0000, 1, 1, 0, 1, 0, 4'b0001));
    // back-pressure on the tlast beat for 5 cycles
    for (int i = 0; i < 5; i++) tv.push_back(mk(0, 4'b0011, 4'b0001, 0, 1, 0, 1, 1, 4'b0000));
    tv.push_back(mk(0, 4'b0011, 4'b0001, 1, 1, 0, 1, 1, 4'b0001));
    tv.push_back(mk(0, 4'b0010, 4'b0010, 1, 0, 0, 0, 0, 4'b0000));
    tv.push_back(mk(0, 4'b0010, 4'b0010, 1, 1, 1, 1, 1, 4'b0010));
    // reset during beat 2, then re-arbitration from the lowest requester
    tv.push_back(mk(0, 4'b1010, 4'b0000, 1, 0, 1, 0, 0, 4'b0000));
    tv.push_back(mk(0, 4'b1010, 4'b0000, 1, 1, 3, 1, 0, 4'b1000));
    tv.push_back(mk(1, 4'b1010, 4'b0000, 1, 1, 3, 1, 0, 4'b1000));
    tv.push_back(mk(0, 4'b1010, 4'b0000, 1, 0, 0, 0, 0, 4'b0000));
    tv.push_back(mk(0, 4'b1010, 4'b0000, 1, 1, 1, 1, 0, 4'b0010));
    // fixed LSB priority: 1010 -> 1 for two beats, bubble, then 3
    fv.push_back(mk(0, 4'b1010, 4'b0000, 1, 0, 0, 0, 0, 4'b0000));
    fv.push_back(mk(0, 4'b1010, 4'b0000, 1, 1, 1, 1, 0, 4'b0010));
    fv.push_back(mk(0, 4'b1010, 4'b0010, 1, 1, 1, 1, 1, 4'b0010));
    fv.push_back(mk(0, 4'b1000, 4'b0000, 1, 0, 1, 0, 0, 4'b0000));
    fv.push_back(mk(0, 4'b1000, 4'b0000, 1, 1, 3, 1, 0, 4'b1000));
    rst = 1'b1; sv = '0; sl = '0; mr = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset busy", busy_rr, 1'b0);
    chk("reset tid", tid_rr, 2'd0);
    chk("reset mvalid", mv_rr, 1'b0);
    chk("reset mlast", ml_rr, 1'b0);
    chk("reset sready", sr_rr, 4'b0000);
    chk("reset tdata", md_rr, 24'h0);
    @(posedge clk);
    #1;
    for (int i = 0; i < tv.size(); i++) step(tv[i], 1'b0, $sformatf("rr%0d", i));
    rst = 1'b1; sv = '0; sl = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < fv.size(); i++) step(fv[i], 1'b1, $sformatf("fp%0d", i));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
